// File: rtl/nn_run_sequencer.sv
// -----------------------------------------------------------------------------
// nn_run_sequencer
//
// Run controller for the convolution engine. On an accepted start it issues
// one go pulse per inference run (num_runs runs, 0 meaning 1), each preceded
// by GO_DELAY idle cycles, and waits up to TIMEOUT cycles for finish. While a
// run is active it snoops the output-memory write bus to count writes, fold a
// rotate-left/XOR checksum and flag out-of-range addresses.
//
// Handshake: go is a single-cycle pulse (high only in the GO state). The engine
// answers with finish, which is acted on only in WAIT; finish in the go cycle
// or while idle/delaying has no effect. A write is dom_enable & dom_write on a
// rising clock edge, counted only in GO and WAIT.
//
// Ports:
//   clk          clock, all logic on rising edge
//   reset        asynchronous active-low reset
//   start        one-cycle request to begin a sequence (IDLE/DONE/ERR only)
//   num_runs     runs to execute, sampled with start
//   go           one-cycle pulse per run to the engine
//   finish       run-complete indication from the engine
//   dom_enable   snooped output-memory enable
//   dom_write    snooped output-memory write strobe
//   dom_address  snooped output-memory address
//   dom_data     snooped output-memory data
//   busy         high from start acceptance until DONE/ERR
//   done         high in DONE until the next accepted start
//   timeout_err  sticky: a run did not finish within TIMEOUT cycles
//   count_err    sticky: a run wrote other than EXPECTED_WRITES words
//   addr_err     sticky: a snooped write addressed >= EXPECTED_WRITES
//   run_index    index of the current/last run
//   cycle_count  go-to-finish latency of the last completed run
//   write_count  writes snooped in the current/last run (saturating)
//   checksum     running checksum of the current/last run
//   fsm_state    debug view of the controller state
// -----------------------------------------------------------------------------
module nn_run_sequencer #(
    parameter int ADDR_W          = 3,
    parameter int DATA_W          = 16,
    parameter int GO_DELAY        = 5,
    parameter int TIMEOUT         = 1024,
    parameter int CNT_W           = 16,
    parameter int RUN_W           = 4,
    parameter int EXPECTED_WRITES = 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic [RUN_W-1:0]  num_runs,
    output logic              go,
    input  logic              finish,
    input  logic              dom_enable,
    input  logic              dom_write,
    input  logic [ADDR_W-1:0] dom_address,
    input  logic [DATA_W-1:0] dom_data,
    output logic              busy,
    output logic              done,
    output logic              timeout_err,
    output logic              count_err,
    output logic              addr_err,
    output logic [RUN_W-1:0]  run_index,
    output logic [CNT_W-1:0]  cycle_count,
    output logic [CNT_W-1:0]  write_count,
    output logic [DATA_W-1:0] checksum,
    output logic [2:0]        fsm_state
);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_DELAY = 3'd1,
        S_GO    = 3'd2,
        S_WAIT  = 3'd3,
        S_DONE  = 3'd4,
        S_ERR   = 3'd5
    } state_t;

    localparam int               DLY_W    = (GO_DELAY > 1) ? $clog2(GO_DELAY) : 1;
    localparam logic [DLY_W-1:0] DLY_LAST = DLY_W'(GO_DELAY - 1);
    localparam logic [CNT_W-1:0] LAT_LAST = CNT_W'(TIMEOUT - 1);
    localparam logic [CNT_W-1:0] WR_EXP   = CNT_W'(EXPECTED_WRITES);

    state_t            state, state_next;
    logic [RUN_W-1:0]  runs;
    logic [DLY_W-1:0]  dly_cnt;
    logic [CNT_W-1:0]  lat_cnt;

    logic              accept;
    logic              run_end;
    logic              timeout_hit;
    logic              last_run;
    logic              wr_hit;
    logic              addr_oob;
    logic [RUN_W:0]    run_next;
    logic [CNT_W-1:0]  wc_inc;
    logic [CNT_W-1:0]  wc_final;
    logic [DATA_W-1:0] cs_next;

    assign run_next = {1'b0, run_index} + (RUN_W+1)'(1);
    assign last_run = (run_next >= {1'b0, runs});

    assign wr_hit   = ((state == S_GO) || (state == S_WAIT)) && dom_enable && dom_write;
    assign addr_oob = ({{(32-ADDR_W){1'b0}}, dom_address} >= 32'(EXPECTED_WRITES));

    // Saturating count; wc_final includes a write landing in the finish cycle.
    assign wc_inc   = (write_count == '1) ? write_count : write_count + CNT_W'(1);
    assign wc_final = wr_hit ? wc_inc : write_count;
    assign cs_next  = {checksum[DATA_W-2:0], checksum[DATA_W-1]} ^ dom_data;

    assign go        = (state == S_GO);
    assign fsm_state = state;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= S_IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next  = state;
        accept      = 1'b0;
        run_end     = 1'b0;
        timeout_hit = 1'b0;
        case (state)
            S_IDLE, S_DONE, S_ERR: begin
                if (start) begin
                    accept     = 1'b1;
                    state_next = S_DELAY;
                end
            end
            S_DELAY: begin
                if (dly_cnt == DLY_LAST) begin
                    state_next = S_GO;
                end
            end
            S_GO: begin
                state_next = S_WAIT;
            end
            S_WAIT: begin
                // finish wins over a timeout landing on the same edge
                if (finish) begin
                    run_end    = 1'b1;
                    state_next = last_run ? S_DONE : S_DELAY;
                end else if (lat_cnt == LAT_LAST) begin
                    timeout_hit = 1'b1;
                    state_next  = S_ERR;
                end
            end
            default: begin
                state_next = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            runs        <= '0;
            dly_cnt     <= '0;
            lat_cnt     <= '0;
            busy        <= 1'b0;
            done        <= 1'b0;
            timeout_err <= 1'b0;
            count_err   <= 1'b0;
            addr_err    <= 1'b0;
            run_index   <= '0;
            cycle_count <= '0;
            write_count <= '0;
            checksum    <= '0;
        end else begin
            if (accept) begin
                runs        <= (num_runs == '0) ? RUN_W'(1) : num_runs;
                run_index   <= '0;
                busy        <= 1'b1;
                done        <= 1'b0;
                timeout_err <= 1'b0;
                count_err   <= 1'b0;
                addr_err    <= 1'b0;
                cycle_count <= '0;
            end

            dly_cnt <= ((state == S_DELAY) && (dly_cnt != DLY_LAST)) ? dly_cnt + DLY_W'(1) : '0;

            // lat_cnt holds j after edge go+j, so the finish edge reports lat_cnt+1.
            if (state == S_GO) begin
                lat_cnt <= CNT_W'(1);
            end else if (state == S_WAIT) begin
                lat_cnt <= lat_cnt + CNT_W'(1);
            end

            // The go cycle restarts the run's accumulators but still counts its own write.
            if (state == S_GO) begin
                write_count <= wr_hit ? CNT_W'(1) : '0;
                checksum    <= wr_hit ? dom_data : '0;
            end else if (wr_hit) begin
                write_count <= wc_inc;
                checksum    <= cs_next;
            end

            if (wr_hit && addr_oob) begin
                addr_err <= 1'b1;
            end

            if (run_end) begin
                cycle_count <= lat_cnt + CNT_W'(1);
                if (wc_final != WR_EXP) begin
                    count_err <= 1'b1;
                end
                if (last_run) begin
                    busy <= 1'b0;
                    done <= 1'b1;
                end else begin
                    run_index <= run_next[RUN_W-1:0];
                end
            end

            if (timeout_hit) begin
                timeout_err <= 1'b1;
                busy        <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_nn_run_sequencer.sv
module tb_nn_run_sequencer;

    localparam int ADDR_W   = 4;
    localparam int DATA_W   = 16;
    localparam int GO_DELAY = 5;
    localparam int TIMEOUT  = 64;
    localparam int CNT_W    = 16;
    localparam int RUN_W    = 4;
    localparam int EXP_WR   = 8;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic reset = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    logic              start = 1'b0;
    logic [RUN_W-1:0]  num_runs = '0;
    logic              finish = 1'b0;
    logic              dom_enable = 1'b0;
    logic              dom_write = 1'b0;
    logic [ADDR_W-1:0] dom_address = '0;
    logic [DATA_W-1:0] dom_data = '0;
    logic              go, busy, done, timeout_err, count_err, addr_err;
    logic [RUN_W-1:0]  run_index;
    logic [CNT_W-1:0]  cycle_count, write_count;
    logic [DATA_W-1:0] checksum;
    logic [2:0]        fsm_state;

    nn_run_sequencer #(
        .ADDR_W(ADDR_W), .DATA_W(DATA_W), .GO_DELAY(GO_DELAY), .TIMEOUT(TIMEOUT),
        .CNT_W(CNT_W), .RUN_W(RUN_W), .EXPECTED_WRITES(EXP_WR)
    ) dut (
        .clk(clk), .reset(reset), .start(start), .num_runs(num_runs), .go(go),
        .finish(finish), .dom_enable(dom_enable), .dom_write(dom_write),
        .dom_address(dom_address), .dom_data(dom_data), .busy(busy), .done(done),
        .timeout_err(timeout_err), .count_err(count_err), .addr_err(addr_err),
        .run_index(run_index), .cycle_count(cycle_count), .write_count(write_count),
        .checksum(checksum), .fsm_state(fsm_state)
    );

    // ---------------- scoreboard ----------------
    typedef struct { int at; int ri; } go_exp_t;
    typedef struct { int at; int ri; int lat; int wc; int cs; int ce; int ae; } run_exp_t;
    typedef struct { int at; int dn; int te; int ce; int ae; int ri; } end_exp_t;

    go_exp_t  exp_go_q[$];
    run_exp_t exp_run_q[$];
    end_exp_t exp_end_q[$];

    int n_cmp = 0;
    int n_bad = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s @cycle %0d: got 0x%0h, expected 0x%0h", name, cyc, act, exp);
        end
    endtask

    // Monitor: pops expectations whenever the DUT presents a go pulse, a run
    // result (edge after finish) or the end of a sequence (busy falling).
    logic prev_busy = 1'b0;
    always @(negedge clk) begin
        if (!reset) begin
            prev_busy = 1'b0;
        end else begin
            if (go) begin
                check("go_pending", 32'(exp_go_q.size() != 0), 1);
                if (exp_go_q.size() != 0) begin
                    go_exp_t g;
                    g = exp_go_q.pop_front();
                    check("go_cycle", cyc, g.at);
                    check("go_run_index", 32'(run_index), g.ri);
                end
            end
            while (exp_run_q.size() != 0 && exp_run_q[0].at <= cyc) begin
                run_exp_t r;
                r = exp_run_q.pop_front();
                check("run_index", 32'(run_index), r.ri);
                check("cycle_count", 32'(cycle_count), r.lat);
                check("write_count", 32'(write_count), r.wc);
                check("checksum", 32'(checksum), r.cs);
                check("count_err", 32'(count_err), r.ce);
                check("addr_err", 32'(addr_err), r.ae);
            end
            if (prev_busy && !busy) begin
                check("end_pending", 32'(exp_end_q.size() != 0), 1);
                if (exp_end_q.size() != 0) begin
                    end_exp_t e;
                    e = exp_end_q.pop_front();
                    check("end_cycle", cyc, e.at);
                    check("end_done", 32'(done), e.dn);
                    check("end_timeout_err", 32'(timeout_err), e.te);
                    check("end_count_err", 32'(count_err), e.ce);
                    check("end_addr_err", 32'(addr_err), e.ae);
                    check("end_run_index", 32'(run_index), e.ri);
                end
            end
            prev_busy = busy;
        end
    end

    // ---------------- driver tasks ----------------
    task automatic adv();
        @(posedge clk);
        #1;
    endtask

    task automatic bus_clear();
        dom_enable  = 1'b0;
        dom_write   = 1'b0;
        dom_address = '0;
        dom_data    = '0;
        finish      = 1'b0;
    endtask

    // Noise outside active runs: must all be ignored by the sequencer.
    task automatic stray();
        dom_enable  = 1'($urandom_range(0, 1));
        dom_write   = 1'($urandom_range(0, 1));
        dom_address = ADDR_W'($urandom_range(0, 15));
        dom_data    = DATA_W'($urandom_range(0, 65535));
        finish      = 1'($urandom_range(0, 1));
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_go"}, 32'(go), 0);
        check({tag, "_busy"}, 32'(busy), 0);
        check({tag, "_done"}, 32'(done), 0);
        check({tag, "_flags"}, {29'd0, timeout_err, count_err, addr_err}, 0);
        check({tag, "_run_index"}, 32'(run_index), 0);
        check({tag, "_cycle_count"}, 32'(cycle_count), 0);
        check({tag, "_write_count"}, 32'(write_count), 0);
        check({tag, "_checksum"}, 32'(checksum), 0);
    endtask

    // mode 0: random 8 writes, 1: data 1..8 to addr 0..7 with finish at 20,
    // 2: 7 writes including addresses 7 and 9, 3: finish never comes.
    task automatic do_sequence(input int nr, input int mode);
        int runs, s_at, e_at, f_at, k, nw, wi, rot, prev_nw, prev_cs, cs, ce, ae;
        int addr_l[8];
        int data_l[8];
        bit do_wr;
        runs = (nr == 0) ? 1 : nr;
        ce = 0;
        ae = 0;
        prev_nw = 0;
        prev_cs = 0;
        repeat ($urandom_range(2, 4)) begin
            stray();
            adv();
        end
        bus_clear();
        start    = 1'b1;
        num_runs = RUN_W'(nr);
        s_at     = cyc + 1;
        adv();
        start    = 1'b0;
        num_runs = RUN_W'($urandom_range(0, 15));
        check("accept_busy", 32'(busy), 1);
        check("accept_done", 32'(done), 0);
        check("accept_flags", {29'd0, timeout_err, count_err, addr_err}, 0);
        check("accept_cycle_count", 32'(cycle_count), 0);
        e_at = s_at + GO_DELAY;
        for (int r = 0; r < runs; r++) begin
            exp_go_q.push_back('{e_at, r});
            while (cyc < e_at) begin
                stray();
                adv();
            end
            if (r > 0) begin
                check("delay_write_count", 32'(write_count), prev_nw);
                check("delay_checksum", 32'(checksum), prev_cs);
            end
            if (mode == 3) begin
                exp_end_q.push_back('{e_at + TIMEOUT, 0, 1, ce, 0, r});
                for (int j = 1; j <= TIMEOUT; j++) begin
                    dom_enable  = 1'($urandom_range(0, 1));
                    dom_write   = 1'($urandom_range(0, 1));
                    dom_address = ADDR_W'($urandom_range(0, 15));
                    dom_data    = DATA_W'($urandom_range(0, 65535));
                    finish      = 1'b0;
                    if (dom_enable && dom_write && int'(dom_address) >= EXP_WR) ae = 1;
                    adv();
                end
                exp_end_q[exp_end_q.size() - 1].ae = ae | exp_end_q[exp_end_q.size() - 1].ae;
                bus_clear();
                repeat (12) adv();
                return;
            end
            rot = $urandom_range(0, 7);
            nw  = (mode == 2) ? 7 : 8;
            k   = (mode == 1) ? 20 : $urandom_range(10, 40);
            for (int i = 0; i < 8; i++) begin
                addr_l[i] = (mode == 1) ? i : (i + rot) % 8;
                data_l[i] = (mode == 1) ? i + 1 : $urandom_range(0, 65535);
            end
            if (mode == 2) begin
                addr_l[5] = 7;
                addr_l[6] = 9;
            end
            cs = 0;
            for (int i = 0; i < nw; i++) begin
                cs = ((cs << 1) | (cs >> 15)) & 32'hFFFF;
                cs = cs ^ data_l[i];
                if (addr_l[i] >= EXP_WR) ae = 1;
            end
            if (nw != EXP_WR) ce = 1;
            f_at = e_at + k;
            exp_run_q.push_back('{f_at, (r == runs - 1) ? r : r + 1, k, nw, cs, ce, ae});
            if (r == runs - 1) exp_end_q.push_back('{f_at, 1, 0, ce, ae, r});
            wi = 0;
            for (int j = 1; j <= k; j++) begin
                if (mode == 1) do_wr = (j <= 8);
                else do_wr = (wi < nw) && ((k - j + 1 <= nw - wi) || ($urandom_range(0, 1) == 1));
                if (do_wr) begin
                    dom_enable  = 1'b1;
                    dom_write   = 1'b1;
                    dom_address = ADDR_W'(addr_l[wi]);
                    dom_data    = DATA_W'(data_l[wi]);
                    wi++;
                end else begin
                    dom_enable  = 1'($urandom_range(0, 1));
                    dom_write   = dom_enable ? 1'b0 : 1'($urandom_range(0, 1));
                    dom_address = ADDR_W'($urandom_range(0, 15));
                    dom_data    = DATA_W'($urandom_range(0, 65535));
                end
                // finish in the go cycle must be ignored
                finish = (j == k) ? 1'b1 : ((j == 1) ? 1'($urandom_range(0, 1)) : 1'b0);
                adv();
            end
            bus_clear();
            prev_nw = nw;
            prev_cs = cs;
            e_at = f_at + GO_DELAY;
        end
        repeat (4) begin
            stray();
            adv();
        end
        bus_clear();
        check("idle_write_count", 32'(write_count), prev_nw);
        check("idle_checksum", 32'(checksum), prev_cs);
        check("idle_done", 32'(done), 1);
    endtask

    task automatic reset_test();
        int s_at;
        bus_clear();
        start    = 1'b1;
        num_runs = RUN_W'(2);
        s_at     = cyc + 1;
        adv();
        start = 1'b0;
        exp_go_q.push_back('{s_at + GO_DELAY, 0});
        while (cyc < s_at + GO_DELAY) adv();
        for (int j = 1; j <= 3; j++) begin
            dom_enable  = 1'b1;
            dom_write   = 1'b1;
            dom_address = ADDR_W'(j);
            dom_data    = DATA_W'($urandom_range(1, 65535));
            adv();
        end
        bus_clear();
        check("pre_reset_busy", 32'(busy), 1);
        check("pre_reset_write_count", 32'(write_count), 3);
        #3;
        reset = 1'b0;
        #1;
        check_all_zero("async_reset");
        repeat (3) @(posedge clk);
        #3;
        reset = 1'b1;
        repeat (5) begin
            stray();
            adv();
        end
        bus_clear();
        check_all_zero("post_reset");
    endtask

    // ---------------- main ----------------
    initial begin
        bus_clear();
        #2;
        check_all_zero("power_on");
        repeat (2) @(posedge clk);
        #3;
        reset = 1'b1;
        adv();
        adv();
        check_all_zero("released");

        do_sequence(1, 1);
        do_sequence(3, 1);
        do_sequence(0, 0);
        do_sequence(2, 2);
        do_sequence(1, 3);
        do_sequence(1, 0);
        for (int n = 0; n < 4; n++) do_sequence($urandom_range(1, 4), 0);
        do_sequence(1, 2);
        reset_test();
        do_sequence(2, 0);
        repeat (5) adv();

        check("go_queue_drained", exp_go_q.size(), 0);
        check("run_queue_drained", exp_run_q.size(), 0);
        check("end_queue_drained", exp_end_q.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #2000000;
        n_bad++;
        $display("FAIL watchdog: simulation did not complete, got stuck at cycle %0d", cyc);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $fatal(1, "watchdog");
    end

endmodule
